// File: rtl/gpreg_seq_pkg.sv
// Shared definitions for the general-purpose register micro-sequencer.
// Holds the request opcode encoding and the sequencer state type.
package gpreg_seq_pkg;

    localparam logic [1:0] OP_MOV = 2'b00;
    localparam logic [1:0] OP_ALU = 2'b01;
    localparam logic [1:0] OP_IN  = 2'b10;
    localparam logic [1:0] OP_OUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_XFER   = 2'd2
    } state_t;

endpackage

// File: rtl/gpreg_sequencer_if.sv
// Register-transfer request channel between the instruction decoder and the sequencer.
// The decoder drives through the master modport; the sequencer uses the slave modport.
interface gpreg_sequencer_if #(
    parameter int IDXW = 2
);
    logic            REQ_valid;
    logic            REQ_ready;
    logic [1:0]      REQ_op;
    logic [IDXW-1:0] REQ_src;
    logic [IDXW-1:0] REQ_rhs;
    logic [IDXW-1:0] REQ_dst;

    modport master (
        output REQ_valid, REQ_op, REQ_src, REQ_rhs, REQ_dst,
        input  REQ_ready
    );

    modport slave (
        input  REQ_valid, REQ_op, REQ_src, REQ_rhs, REQ_dst,
        output REQ_ready
    );
endinterface

// File: rtl/onehot_bar_dec.sv
// Index-to-strobe decoder: active-low one-hot of idx when enabled.
// Yields all ones when disabled or when idx does not name an existing register.
module onehot_bar_dec #(
    parameter int NREGS = 4,
    parameter int IDXW  = 2
) (
    input  logic [IDXW-1:0]  idx,
    input  logic             en,
    output logic [NREGS-1:0] bar
);

    always_comb begin
        bar = '1;
        for (int i = 0; i < NREGS; i++) begin
            if (en && (32'(idx) == i)) begin
                bar[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/gpreg_sequencer.sv
// Micro-sequencer issuing register-bank bus strobes for one transfer request at a time.
// Define GPREG_SEQ_FAST_EN to skip the SETTLE cycle (2-cycle instead of 3-cycle requests).
module gpreg_sequencer
    import gpreg_seq_pkg::*;
#(
    parameter int NREGS = 4,
    parameter int IDXW  = 2
) (
    input  logic                CLK,
    input  logic                RST,
    gpreg_sequencer_if.slave    req,
    output logic [NREGS-1:0]    LOAD_bar,
    output logic [NREGS-1:0]    ASSERT_bar,
    output logic [NREGS-1:0]    ASSERT_LHS_bar,
    output logic [NREGS-1:0]    ASSERT_RHS_bar,
    output logic                ALU_ASSERT_bar,
    output logic                EXT_ASSERT_bar,
    output logic                EXT_LOAD_bar,
    output logic                DONE,
    output logic                ERR
);

    state_t          state;
    state_t          state_nx;
    logic            accept;

    logic [1:0]      op_q, op_nx;
    logic [IDXW-1:0] src_q, src_nx;
    logic [IDXW-1:0] rhs_q, rhs_nx;
    logic [IDXW-1:0] dst_q, dst_nx;
    logic            err_q, err_nx;
    logic            ready_q;

    logic            bus_en, lr_en, load_en;
    logic            alu_assert_d, ext_assert_d, ext_load_d, done_d, err_d, ready_d;
    logic [NREGS-1:0] load_d, assert_d, lhs_d, rhs_d;

    function automatic logic out_of_range(input logic [IDXW-1:0] idx);
        return 32'(idx) >= NREGS;
    endfunction

    assign accept        = (state == ST_IDLE) && req.REQ_valid;
    assign req.REQ_ready = ready_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (req.REQ_valid) begin
`ifdef GPREG_SEQ_FAST_EN
                    state_nx = ST_XFER;
`else
                    state_nx = ST_SETTLE;
`endif
                end
            end
            ST_SETTLE: state_nx = ST_XFER;
            ST_XFER:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Request fields seen by the output logic: fresh from the bus on accept, else the latched copy.
    always_comb begin
        op_nx  = op_q;
        src_nx = src_q;
        rhs_nx = rhs_q;
        dst_nx = dst_q;
        err_nx = err_q;
        if (accept) begin
            op_nx  = req.REQ_op;
            src_nx = req.REQ_src;
            rhs_nx = req.REQ_rhs;
            dst_nx = req.REQ_dst;
            case (req.REQ_op)
                OP_MOV:  err_nx = out_of_range(req.REQ_src) || out_of_range(req.REQ_dst);
                OP_ALU:  err_nx = out_of_range(req.REQ_src) || out_of_range(req.REQ_rhs)
                                  || out_of_range(req.REQ_dst);
                OP_IN:   err_nx = out_of_range(req.REQ_dst);
                default: err_nx = out_of_range(req.REQ_src);
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            op_q  <= OP_MOV;
            src_q <= '0;
            rhs_q <= '0;
            dst_q <= '0;
            err_q <= 1'b0;
        end else begin
            op_q  <= op_nx;
            src_q <= src_nx;
            rhs_q <= rhs_nx;
            dst_q <= dst_nx;
            err_q <= err_nx;
        end
    end

    // Strobe values for the coming cycle, derived from the state being entered so every output is a flop.
    always_comb begin
        bus_en       = 1'b0;
        lr_en        = 1'b0;
        load_en      = 1'b0;
        alu_assert_d = 1'b1;
        ext_assert_d = 1'b1;
        ext_load_d   = 1'b1;
        if ((state_nx != ST_IDLE) && !err_nx) begin
            bus_en       = (op_nx == OP_MOV) || (op_nx == OP_OUT);
            lr_en        = (op_nx == OP_ALU);
            ext_assert_d = !(op_nx == OP_IN);
            if (state_nx == ST_XFER) begin
                load_en      = (op_nx != OP_OUT);
                alu_assert_d = !(op_nx == OP_ALU);
                ext_load_d   = !(op_nx == OP_OUT);
            end
        end
        done_d  = (state == ST_XFER);
        err_d   = (state == ST_XFER) && err_q;
        ready_d = (state_nx == ST_IDLE);
    end

    onehot_bar_dec #(.NREGS(NREGS), .IDXW(IDXW)) u_dec_assert (
        .idx (src_nx),
        .en  (bus_en),
        .bar (assert_d)
    );

    onehot_bar_dec #(.NREGS(NREGS), .IDXW(IDXW)) u_dec_lhs (
        .idx (src_nx),
        .en  (lr_en),
        .bar (lhs_d)
    );

    onehot_bar_dec #(.NREGS(NREGS), .IDXW(IDXW)) u_dec_rhs (
        .idx (rhs_nx),
        .en  (lr_en),
        .bar (rhs_d)
    );

    onehot_bar_dec #(.NREGS(NREGS), .IDXW(IDXW)) u_dec_load (
        .idx (dst_nx),
        .en  (load_en),
        .bar (load_d)
    );

    // Reset releases every strobe asynchronously so an interrupted load never completes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            LOAD_bar       <= '1;
            ASSERT_bar     <= '1;
            ASSERT_LHS_bar <= '1;
            ASSERT_RHS_bar <= '1;
            ALU_ASSERT_bar <= 1'b1;
            EXT_ASSERT_bar <= 1'b1;
            EXT_LOAD_bar   <= 1'b1;
            DONE           <= 1'b0;
            ERR            <= 1'b0;
            ready_q        <= 1'b0;
        end else begin
            LOAD_bar       <= load_d;
            ASSERT_bar     <= assert_d;
            ASSERT_LHS_bar <= lhs_d;
            ASSERT_RHS_bar <= rhs_d;
            ALU_ASSERT_bar <= alu_assert_d;
            EXT_ASSERT_bar <= ext_assert_d;
            EXT_LOAD_bar   <= ext_load_d;
            DONE           <= done_d;
            ERR            <= err_d;
            ready_q        <= ready_d;
        end
    end

endmodule

// File: tb/tb_gpreg_sequencer.sv
// Self-checking bench: a 4-register and a 3-register sequencer share one stimulus stream
// and are compared every cycle against a phase-based reference model.
module tb_gpreg_sequencer;
    import gpreg_seq_pkg::*;

    localparam int PH_IDLE   = 0;
    localparam int PH_SETTLE = 1;
    localparam int PH_XFER   = 2;
    localparam int PH_DONE   = 3;
    localparam int PH_RESET  = 4;

    typedef struct packed {
        logic [15:0] load;
        logic [15:0] asrt;
        logic [15:0] lhs;
        logic [15:0] rhs;
        logic        alu;
        logic        exta;
        logic        extl;
        logic        done;
        logic        err;
        logic        ready;
    } exp_t;

    logic CLK;
    logic RST;
    int   total;
    int   bad;

    logic [3:0] d4_load, d4_asrt, d4_lhs, d4_rhs;
    logic       d4_alu, d4_exta, d4_extl, d4_done, d4_err;
    logic [2:0] d3_load, d3_asrt, d3_lhs, d3_rhs;
    logic       d3_alu, d3_exta, d3_extl, d3_done, d3_err;

    gpreg_sequencer_if #(.IDXW(2)) if4 ();
    gpreg_sequencer_if #(.IDXW(2)) if3 ();

    gpreg_sequencer #(.NREGS(4), .IDXW(2)) dut4 (
        .CLK            (CLK),
        .RST            (RST),
        .req            (if4),
        .LOAD_bar       (d4_load),
        .ASSERT_bar     (d4_asrt),
        .ASSERT_LHS_bar (d4_lhs),
        .ASSERT_RHS_bar (d4_rhs),
        .ALU_ASSERT_bar (d4_alu),
        .EXT_ASSERT_bar (d4_exta),
        .EXT_LOAD_bar   (d4_extl),
        .DONE           (d4_done),
        .ERR            (d4_err)
    );

    gpreg_sequencer #(.NREGS(3), .IDXW(2)) dut3 (
        .CLK            (CLK),
        .RST            (RST),
        .req            (if3),
        .LOAD_bar       (d3_load),
        .ASSERT_bar     (d3_asrt),
        .ASSERT_LHS_bar (d3_lhs),
        .ASSERT_RHS_bar (d3_rhs),
        .ALU_ASSERT_bar (d3_alu),
        .EXT_ASSERT_bar (d3_exta),
        .EXT_LOAD_bar   (d3_extl),
        .DONE           (d3_done),
        .ERR            (d3_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Active-low one-hot over n registers; bits at and above n are zero so they compare against zero-extended DUT buses.
    function automatic logic [15:0] onecold(input int idx, input bit en, input int n);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < n; i++) begin
            v[i] = !(en && (i == idx));
        end
        return v;
    endfunction

    // Expected outputs for a request in a given phase, written from the transfer rules rather than any encoding.
    function automatic exp_t model(input int op, input int src, input int rhs, input int dst,
                                   input int n, input int ph);
        exp_t e;
        bit   oor;
        bit   drive;
        bit   ld;
        case (op)
            OP_MOV:  oor = (src >= n) || (dst >= n);
            OP_ALU:  oor = (src >= n) || (rhs >= n) || (dst >= n);
            OP_IN:   oor = (dst >= n);
            default: oor = (src >= n);
        endcase
        drive  = ((ph == PH_SETTLE) || (ph == PH_XFER)) && !oor;
        ld     = (ph == PH_XFER) && !oor;
        e.asrt = onecold(src, drive && ((op == OP_MOV) || (op == OP_OUT)), n);
        e.lhs  = onecold(src, drive && (op == OP_ALU), n);
        e.rhs  = onecold(rhs, drive && (op == OP_ALU), n);
        e.load = onecold(dst, ld && (op != OP_OUT), n);
        e.alu  = !(ld && (op == OP_ALU));
        e.exta = !(drive && (op == OP_IN));
        e.extl = !(ld && (op == OP_OUT));
        e.done = (ph == PH_DONE);
        e.err  = (ph == PH_DONE) && oor;
        e.ready = (ph == PH_DONE) || (ph == PH_IDLE);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
            $error("[TB] check %s did not match", tag);
        end
    endtask

    task automatic drive(input logic v, input int op, input int src, input int rhs, input int dst);
        if4.REQ_valid = v;
        if4.REQ_op    = 2'(op);
        if4.REQ_src   = 2'(src);
        if4.REQ_rhs   = 2'(rhs);
        if4.REQ_dst   = 2'(dst);
        if3.REQ_valid = v;
        if3.REQ_op    = 2'(op);
        if3.REQ_src   = 2'(src);
        if3.REQ_rhs   = 2'(rhs);
        if3.REQ_dst   = 2'(dst);
    endtask

    // Garbage on the request bus while busy; it must be ignored.
    task automatic scramble();
        drive(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
    endtask

    task automatic checkOutput(input string tag, input int op, input int src, input int rhs,
                               input int dst, input int ph);
        exp_t e4;
        exp_t e3;
        e4 = model(op, src, rhs, dst, 4, ph);
        e3 = model(op, src, rhs, dst, 3, ph);
        check({tag, ".n4.load"},  32'(d4_load),         32'(e4.load));
        check({tag, ".n4.asrt"},  32'(d4_asrt),         32'(e4.asrt));
        check({tag, ".n4.lhs"},   32'(d4_lhs),          32'(e4.lhs));
        check({tag, ".n4.rhs"},   32'(d4_rhs),          32'(e4.rhs));
        check({tag, ".n4.alu"},   32'(d4_alu),          32'(e4.alu));
        check({tag, ".n4.exta"},  32'(d4_exta),         32'(e4.exta));
        check({tag, ".n4.extl"},  32'(d4_extl),         32'(e4.extl));
        check({tag, ".n4.done"},  32'(d4_done),         32'(e4.done));
        check({tag, ".n4.err"},   32'(d4_err),          32'(e4.err));
        check({tag, ".n4.ready"}, 32'(if4.REQ_ready),   32'(e4.ready));
        check({tag, ".n3.load"},  32'(d3_load),         32'(e3.load));
        check({tag, ".n3.asrt"},  32'(d3_asrt),         32'(e3.asrt));
        check({tag, ".n3.lhs"},   32'(d3_lhs),          32'(e3.lhs));
        check({tag, ".n3.rhs"},   32'(d3_rhs),          32'(e3.rhs));
        check({tag, ".n3.alu"},   32'(d3_alu),          32'(e3.alu));
        check({tag, ".n3.exta"},  32'(d3_exta),         32'(e3.exta));
        check({tag, ".n3.extl"},  32'(d3_extl),         32'(e3.extl));
        check({tag, ".n3.done"},  32'(d3_done),         32'(e3.done));
        check({tag, ".n3.err"},   32'(d3_err),          32'(e3.err));
        check({tag, ".n3.ready"}, 32'(if3.REQ_ready),   32'(e3.ready));
    endtask

    // Entered #1 after an edge with the sequencer idle; leaves #1 into the DONE cycle so the next request is back-to-back.
    task automatic applyStimulus(input int op, input int src, input int rhs, input int dst);
        drive(1'b1, op, src, rhs, dst);
        @(posedge CLK);
        #1;
`ifndef GPREG_SEQ_FAST_EN
        scramble();
        checkOutput("settle", op, src, rhs, dst, PH_SETTLE);
        @(posedge CLK);
        #1;
`endif
        scramble();
        checkOutput("xfer", op, src, rhs, dst, PH_XFER);
        @(posedge CLK);
        #1;
        drive(1'b0, 0, 0, 0, 0);
        checkOutput("done", op, src, rhs, dst, PH_DONE);
    endtask

    task automatic idleCycle();
        drive(1'b0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3));
        @(posedge CLK);
        #1;
        checkOutput("idle", 0, 0, 0, 0, PH_IDLE);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        RST   = 1'b1;
        drive(1'b0, 0, 0, 0, 0);
        #12;
        checkOutput("por", 0, 0, 0, 0, PH_RESET);
        RST = 1'b0;
        #1;
        checkOutput("por_release", 0, 0, 0, 0, PH_RESET);
        @(posedge CLK);
        #1;
        checkOutput("first_ready", 0, 0, 0, 0, PH_IDLE);

        // Directed transfers, the IN/OUT pair presented in the DONE cycle of the IN.
        applyStimulus(OP_MOV, 0, 0, 3);
        idleCycle();
        applyStimulus(OP_ALU, 1, 2, 1);
        idleCycle();
        applyStimulus(OP_IN, 0, 0, 2);
        applyStimulus(OP_OUT, 2, 0, 0);
        applyStimulus(OP_MOV, 3, 0, 0);
        applyStimulus(OP_MOV, 2, 0, 1);
        idleCycle();

        // Reset asserted in the middle of the load cycle of MOV r1->r2.
        drive(1'b1, OP_MOV, 1, 0, 2);
        @(posedge CLK);
        #1;
        drive(1'b0, 0, 0, 0, 0);
`ifndef GPREG_SEQ_FAST_EN
        checkOutput("mid_settle", OP_MOV, 1, 0, 2, PH_SETTLE);
        @(posedge CLK);
        #1;
`endif
        checkOutput("mid_xfer", OP_MOV, 1, 0, 2, PH_XFER);
        #2;
        RST = 1'b1;
        #1;
        checkOutput("mid_rst", 0, 0, 0, 0, PH_RESET);
        @(posedge CLK);
        #1;
        checkOutput("mid_rst_hold", 0, 0, 0, 0, PH_RESET);
        RST = 1'b0;
        #1;
        checkOutput("mid_release", 0, 0, 0, 0, PH_RESET);
        @(posedge CLK);
        #1;
        checkOutput("mid_ready", 0, 0, 0, 0, PH_IDLE);

        for (int k = 0; k < 80; k++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                idleCycle();
            end
            applyStimulus($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3));
        end
        idleCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
